// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock that shares one uart_tx byte transmitter
// between NREQ byte-stream requesters, paced off the transmitter's tx_bsy.

module uart_tx_arbiter_lane #(
  parameter int unsigned IW  = 2,
  parameter int unsigned IDX = 0
) (
  input  logic          valid_i,
  input  logic          lock_i,
  input  logic [IW-1:0] owner_i,
  input  logic [IW-1:0] win_i,
  input  logic          acc_i,
  output logic          cand_o,
  output logic          ready_o
);
  localparam logic [IW-1:0] ME = IW'(IDX);

  // A held lock narrows the candidate set to the owner alone.
  assign cand_o  = valid_i & (~lock_i | (owner_i == ME));
  assign ready_o = acc_i & (win_i == ME);
endmodule

module uart_tx_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned LOCK_TIMEOUT = 64,
  parameter int unsigned BSY_WAIT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              send_trig,
  output logic [7:0]        send_data,
  input  logic              tx_bsy,
  output logic [NREQ-1:0]   grant,
  output logic              locked,
  output logic              lock_abort,
  output logic              bsy_err
);
  localparam int unsigned   IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned   CW       = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned   HW       = $clog2(BSY_WAIT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [HW-1:0] HI_MAX   = HW'(BSY_WAIT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q, owner_q;
  logic            lock_q;
  logic [CW-1:0]   idle_cnt_q;
  logic [HW-1:0]   hi_cnt_q;
  logic [NREQ-1:0] grant_q;
  logic [7:0]      send_data_q;
  logic            send_trig_q, lock_abort_q, bsy_err_q;

  logic [NREQ-1:0][7:0] data_arr;
  logic [NREQ-1:0]      cand, ready;
  logic [IW-1:0]        win;
  logic                 found, acc, exit_frm, owner_vld;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign data_arr  = req_data;
  assign owner_vld = req_valid[owner_q];

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    uart_tx_arbiter_lane #(.IW(IW), .IDX(g)) u_lane (
      .valid_i (req_valid[g]),
      .lock_i  (lock_q),
      .owner_i (owner_q),
      .win_i   (win),
      .acc_i   (acc),
      .cand_o  (cand[g]),
      .ready_o (ready[g])
    );
  end

  // First candidate at/after ptr, walking with an explicit wrap at NREQ-1.
  always_comb begin
    logic [IW-1:0] idx;
    idx   = ptr_q;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = next_idx(idx);
    end
  end

  assign acc      = (state_q == IDLE) & ~tx_bsy & found & ~rst;
  assign exit_frm = ~tx_bsy & ((state_q == WAIT_LO) |
                               ((state_q == WAIT_HI) & (hi_cnt_q == HI_MAX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      lock_q       <= 1'b0;
      idle_cnt_q   <= '0;
      hi_cnt_q     <= '0;
      grant_q      <= '0;
      send_data_q  <= '0;
      send_trig_q  <= 1'b0;
      lock_abort_q <= 1'b0;
      bsy_err_q    <= 1'b0;
    end else begin
      send_trig_q  <= 1'b0;
      lock_abort_q <= 1'b0;
      bsy_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc) begin
            send_data_q <= data_arr[win];
            grant_q     <= onehot(win);
            owner_q     <= win;
            lock_q      <= ~req_last[win];
            idle_cnt_q  <= '0;
            hi_cnt_q    <= '0;
            send_trig_q <= 1'b1;
            state_q     <= WAIT_HI;
          end else if (lock_q && !owner_vld) begin
            if (idle_cnt_q == CNT_MAX) begin
              lock_q       <= 1'b0;
              grant_q      <= '0;
              ptr_q        <= next_idx(owner_q);
              lock_abort_q <= 1'b1;
              idle_cnt_q   <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
        end
        WAIT_HI: begin
          if (tx_bsy)
            state_q <= WAIT_LO;
          else if (hi_cnt_q == HI_MAX)
            bsy_err_q <= 1'b1;
          else
            hi_cnt_q <= hi_cnt_q + 1'b1;
        end
        WAIT_LO: ;
        default: state_q <= IDLE;
      endcase
      // A missing tx_bsy is treated as a completed frame and leaves the same way.
      if (exit_frm) begin
        state_q <= IDLE;
        if (!lock_q) begin
          grant_q <= '0;
          ptr_q   <= next_idx(owner_q);
        end
      end
    end
  end

  assign req_ready  = ready;
  assign send_trig  = send_trig_q;
  assign send_data  = send_data_q;
  assign grant      = grant_q;
  assign locked     = lock_q;
  assign lock_abort = lock_abort_q;
  assign bsy_err    = bsy_err_q;
endmodule
